fp16_norm_round: RTL and testbench
==================================

// Module: fp16_norm_round
// PURPOSE
//  Sequential normalise-and-round stage after the half-precision mantissa multiplier and exponent adder.
//  - Consumes the raw 22-bit mantissa product and the biased exponent sum.
//  - Produces the packed fp16 product with status flags.
//  - Iterative shifter: left-normalises one bit per cycle, and denormalises tiny results one bit per cycle.
//  - Rounds to nearest-even.
//  - valid/ready on both sides; one operation in flight.
// PARAMETERS
//  EXP_W   5   exponent field width
//  MANT_W  10  stored mantissa width; product width PW = 2*(MANT_W+1) = 22
//  BIAS    15  exponent bias
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    asynchronous, active-high reset
//  in_valid      in   1    operand bundle valid
//  in_ready      out  1    stage can accept; equals (state==IDLE)
//  in_sign       in   1    product sign (0 in unsigned flow)
//  in_exp_sum    in   7    biased exponent sum ea+eb, 0..62
//  in_mant_prod  in   22   {1.ma}*{1.mb}, fixed point U2.20 (bit 20 = 1's place)
//  out_valid     out  1    result valid; held until out_ready
//  out_ready     in   1    consumer accepts result
//  out_result    out  16   {sign, exp[4:0], mant[9:0]}
//  out_flags     out  3    {overflow, underflow, inexact}
// BEHAVIOUR
//  Reset:
//  - state=IDLE, out_valid=0, out_result=0, out_flags=0, in_ready=1.
//  - Reset mid-operation aborts the operation; nothing is emitted.
//  Accept: in_valid & in_ready at a rising edge captures:
//  - p = in_mant_prod;
//  - w = in_exp_sum - BIAS, 8-bit signed working biased exponent;
//  - sticky = 0.
//  States: IDLE -> NORM -> [DENORM] -> ROUND -> DONE -> IDLE.
//  NORM:
//  - p==0 -> result {sign,15'b0}, flags 000, go ROUND (result forced to zero).
//  - p[21]=1 -> p>>=1, sticky|=p[0], w+=1, go on.
//  - p[20]=0 & w>1 -> p<<=1, w-=1, stay in NORM (one shift per cycle).
//  - Otherwise go on.
//  - Go-on target:
//    - w < -MANT_W (i.e. w < -10) -> flush: p=0, sticky=1, go ROUND.
//    - w <= 0 -> go DENORM.
//    - else -> go ROUND.
//  DENORM: each cycle p>>=1, sticky|=p[0], w+=1; when w==1 go ROUND.
//  ROUND:
//  - Fields: m = p[19:10], g = p[9], s = sticky | (|p[8:0]).
//  - Exponent field e = p[20] ? w[4:0] : 0.
//  - Round up if g & (s | m[0]); add 1 to {e,m} as 15-bit value (mantissa carry bumps exponent, subnormal->normal included).
//  - If e >= 31 after rounding: result {sign,5'h1F,10'h0}, overflow=1, inexact=1.
//  - inexact = g|s.
//  - underflow = nonzero p entering DENORM/flush, i.e. tiny before rounding.
//  DONE:
//  - out_valid=1; out_result and out_flags stable.
//  - out_ready -> IDLE next edge, out_valid=0.
//  - in_ready is 0 in DONE; a new operand is accepted no earlier than the cycle after handoff.
//  Latency:
//  - out_valid rises 2 + L + D edges after the accept edge; L = left shifts, D = denorm shifts.
//  - Max latency 2+20+11.
//  - Zero product: latency 2.
//  Outputs are registered. in_* are ignored outside IDLE.
// TESTING
//  1 exp_sum=30, prod=22'h100000 -> result 16'h3C00, flags 000, out_valid 2 edges after accept
//  2 exp_sum=31, prod=22'h240000 (1.5*1.5) -> 16'h4480, flags 000, latency 2
//  3 exp_sum=30, prod=22'h100200 -> 16'h3C00 inexact=1 (tie, even kept); prod=22'h100600 -> 16'h3C02 inexact=1
//  4 exp_sum=60, prod=22'h300000 -> 16'h7C00, flags 101; exp_sum=10, prod=22'h100000 -> 16'h0010, flags 010, latency 8
//  5 exp_sum=30, prod=22'h000800 (L=9) -> 16'h1800, latency 11
//  5 (cont.) exp_sum=2, prod=22'h100000 -> flush, 16'h0000, flags 011
//  6 out_ready low 5 cycles -> result/out_valid held, in_ready=0
//  6 (cont.) rst pulse during DENORM -> IDLE, out_valid=0, next op correct

Source files
------------

// File: rtl/fp16_norm_round_if.sv
// Handshake bundle between the mantissa multiplier and the normalise/round stage.
interface fp16_norm_round_if #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
);
  localparam int PW = 2 * (MANT_W + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W+1:0]        in_exp_sum;
  logic [PW-1:0]           in_mant_prod;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W:0]   out_result;
  logic [2:0]              out_flags;

  modport master (
    output in_valid, in_sign, in_exp_sum, in_mant_prod, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp_sum, in_mant_prod, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp16_norm_round.sv
// Iterative normalise / denormalise / round-to-nearest-even stage for the fp16 multiplier.
// state  | meaning
// IDLE   | waiting for an operand bundle, in_ready high
// NORM   | left-normalise one bit per cycle, or single right shift on product overflow
// DENORM | shift a tiny result right one bit per cycle until exponent reaches 1
// ROUND  | round to nearest-even, pack result and flags
// DONE   | hold result until consumer accepts
module fp16_norm_round #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10,
  parameter int BIAS   = 15
) (
  input  logic              clk,
  input  logic              rst,
  fp16_norm_round_if.slave  bus
);
  localparam int PW   = 2 * (MANT_W + 1);
  localparam int WW   = EXP_W + 3;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [WW-1:0] W_ONE = WW'(1);
  localparam logic signed [WW-1:0] W_MIN = WW'(-MANT_W);

  typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, DONE} state_t;

  state_t                 state;
  logic [PW-1:0]          p;
  logic signed [WW-1:0]   w;
  logic                   sticky;
  logic                   unf;
  logic                   sign;

  logic signed [WW-1:0]   w_go;
  logic [MANT_W-1:0]      rnd_m;
  logic                   rnd_g;
  logic                   rnd_s;
  logic                   rnd_up;
  logic                   rnd_ovf;
  logic [WW-1:0]          rnd_e;
  logic [WW+MANT_W-1:0]   rnd_sum;

  assign bus.in_ready = (state == IDLE);

  always_comb begin
    w_go    = p[PW-1] ? (w + W_ONE) : w;
    rnd_m   = p[PW-3 -: MANT_W];
    rnd_g   = p[PW-3-MANT_W];
    rnd_s   = sticky | (|p[PW-4-MANT_W:0]);
    // Only a normalised significand carries the exponent; otherwise it is a subnormal.
    rnd_e   = p[PW-2] ? w : '0;
    rnd_up  = rnd_g & (rnd_s | rnd_m[0]);
    rnd_sum = {rnd_e, rnd_m} + (WW+MANT_W)'(rnd_up);
    rnd_ovf = rnd_sum[WW+MANT_W-1:MANT_W] >= WW'(EMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      p              <= '0;
      w              <= '0;
      sticky         <= 1'b0;
      unf            <= 1'b0;
      sign           <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p      <= bus.in_mant_prod;
            w      <= $signed({1'b0, bus.in_exp_sum}) - WW'(BIAS);
            sticky <= 1'b0;
            unf    <= 1'b0;
            sign   <= bus.in_sign;
            state  <= NORM;
          end
        end
        NORM: begin
          if (p == '0) begin
            state <= ROUND;
          end else if (!p[PW-1] && !p[PW-2] && (w > W_ONE)) begin
            p <= p << 1;
            w <= w - W_ONE;
          end else begin
            if (p[PW-1]) begin
              p      <= p >> 1;
              sticky <= sticky | p[0];
              w      <= w_go;
            end
            // Too small to survive even as a subnormal: flush, keep only inexactness.
            if (w_go < W_MIN) begin
              p      <= '0;
              sticky <= 1'b1;
              unf    <= 1'b1;
              state  <= ROUND;
            end else if (w_go <= 0) begin
              unf   <= 1'b1;
              state <= DENORM;
            end else begin
              state <= ROUND;
            end
          end
        end
        DENORM: begin
          p      <= p >> 1;
          sticky <= sticky | p[0];
          w      <= w + W_ONE;
          if (w == '0) state <= ROUND;
        end
        ROUND: begin
          bus.out_result <= rnd_ovf ? {sign, EXP_W'(EMAX), MANT_W'(0)}
                                    : {sign, rnd_sum[EXP_W+MANT_W-1:0]};
          bus.out_flags  <= {rnd_ovf, unf, rnd_ovf | rnd_g | rnd_s};
          bus.out_valid  <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed and randomized checks of fp16_norm_round against a value-level rounding model.
module tb_fp16_norm_round;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp16_norm_round_if bus ();
  fp16_norm_round dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Exact value = prod * 2^(exp_sum-15-35); round at the fp16 quantum of the result's binade.
  function automatic void ref_model(input logic sg, input int es, input logic [21:0] pr,
                                    output logic [15:0] r, output logic [2:0] f, output int lat);
    int w0, k, wn, wg, e, sh, fe, nl, nd;
    longint unsigned q, rem, half;
    logic inx, tiny, flush;
    r = {sg, 15'd0};
    f = 3'b000;
    lat = 2;
    if (pr == 22'd0) return;
    w0 = es - 15;
    k = 0;
    for (int i = 0; i < 22; i++) if (pr[i]) k = i;
    wn = w0 + k - 20;
    if (k >= 20) wg = wn;
    else if (w0 > 1) wg = (wn > 1) ? wn : 1;
    else wg = w0;
    nl = (k < 20 && w0 > 1) ? (w0 - wg) : 0;
    flush = (wg < -10);
    tiny = (wg <= 0);
    nd = (tiny && !flush) ? (1 - wg) : 0;
    lat = 2 + nl + nd;
    if (flush) begin
      f = 3'b011;
      return;
    end
    e = (wn > 1) ? wn : 1;
    sh = w0 - e - 10;
    if (sh >= 0) begin
      q = 64'(pr) << sh;
      inx = 1'b0;
    end else begin
      q = 64'(pr) >> (-sh);
      rem = 64'(pr) & ((64'd1 << (-sh)) - 64'd1);
      half = 64'd1 << (-sh - 1);
      inx = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end
    if (q >= 64'd2048) begin
      e = e + 1;
      q = q >> 1;
    end
    fe = (q >= 64'd1024) ? e : 0;
    if (fe >= 31) begin
      r = {sg, 5'h1F, 10'h0};
      f = {1'b1, tiny, 1'b1};
    end else begin
      r = {sg, 5'(fe), q[9:0]};
      f = {1'b0, tiny, inx};
    end
  endfunction

  task automatic run_op(input string tag, input logic sg, input logic [6:0] es, input logic [21:0] pr,
                        input int stall, input bit use_ref,
                        input logic [15:0] r_in, input logic [2:0] f_in, input int l_in);
    logic [15:0] er;
    logic [2:0]  ef;
    int          el;
    int          lat;
    if (use_ref) ref_model(sg, int'(es), pr, er, ef, el);
    else begin
      er = r_in;
      ef = f_in;
      el = l_in;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign = sg;
    bus.in_exp_sum = es;
    bus.in_mant_prod = pr;
    bus.out_ready = 1'b0;
    chk({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'($urandom);
    bus.in_exp_sum = 7'($urandom);
    bus.in_mant_prod = 22'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(el));
    chk({tag, "/result"}, 32'(bus.out_result), 32'(er));
    chk({tag, "/flags"}, 32'(bus.out_flags), 32'(ef));
    chk({tag, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "/held_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "/held_result"}, 32'(bus.out_result), 32'(er));
      chk({tag, "/held_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "/in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [21:0] pr;
    logic [6:0]  es;
    logic [10:0] ma, mb;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp_sum = '0;
    bus.in_mant_prod = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset/out_result", 32'(bus.out_result), 32'd0);
    chk("reset/out_flags", 32'(bus.out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("one",        1'b0, 7'd30, 22'h100000, 0, 1'b0, 16'h3C00, 3'b000, 2);
    run_op("ovf_prod",   1'b0, 7'd31, 22'h240000, 0, 1'b0, 16'h4480, 3'b000, 2);
    run_op("tie_even",   1'b0, 7'd30, 22'h100200, 0, 1'b0, 16'h3C00, 3'b001, 2);
    run_op("tie_odd",    1'b0, 7'd30, 22'h100600, 0, 1'b0, 16'h3C02, 3'b001, 2);
    run_op("overflow",   1'b0, 7'd60, 22'h300000, 0, 1'b0, 16'h7C00, 3'b101, 2);
    run_op("subnormal",  1'b0, 7'd10, 22'h100000, 0, 1'b0, 16'h0010, 3'b010, 8);
    run_op("left9",      1'b0, 7'd30, 22'h000800, 0, 1'b0, 16'h1800, 3'b000, 11);
    run_op("flush",      1'b0, 7'd2,  22'h100000, 0, 1'b0, 16'h0000, 3'b011, 2);
    run_op("zero",       1'b1, 7'd40, 22'h000000, 0, 1'b0, 16'h8000, 3'b000, 2);
    run_op("stall",      1'b1, 7'd31, 22'h240000, 5, 1'b0, 16'hC480, 3'b000, 2);

    // Reset pulse while the subnormal path is shifting.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign = 1'b0;
    bus.in_exp_sum = 7'd10;
    bus.in_mant_prod = 22'h100000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst/out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst/in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst/out_result", 32'(bus.out_result), 32'd0);
    chk("midrst/out_flags", 32'(bus.out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst/no_emit", 32'(bus.out_valid), 32'd0);
    run_op("after_rst",  1'b0, 7'd30, 22'h100000, 0, 1'b0, 16'h3C00, 3'b000, 2);

    for (int n = 0; n < 200; n++) begin
      es = 7'($urandom_range(0, 62));
      ma = 11'(1024 + $urandom_range(0, 1023));
      mb = 11'(1024 + $urandom_range(0, 1023));
      pr = 22'(ma) * 22'(mb);
      if ($urandom_range(0, 3) == 0) pr = pr >> $urandom_range(1, 21);
      if ($urandom_range(0, 15) == 0) pr = 22'd0;
      run_op("rand", 1'($urandom), es, pr, $urandom_range(0, 2), 1'b1, 16'h0, 3'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
